// File: rtl/mix_columns_seq_if.sv
// Handshake bundle between ShiftRows, the MixColumns stage and AddRoundKey.
//
// Valid/ready rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both 1. A source holding valid must keep
// its payload stable until that edge. A sink may raise or lower ready freely.
// Input channel:  In_Valid / In_Ready carry Input_State and Bypass.
// Output channel: Out_Valid / Out_Ready carry Output_State.
interface mix_columns_seq_if #(
    parameter int Nb = 128
);
    logic          In_Valid;
    logic          In_Ready;
    logic [Nb-1:0] Input_State;
    logic          Bypass;
    logic          Out_Valid;
    logic          Out_Ready;
    logic [Nb-1:0] Output_State;

    // Environment side: produces input blocks and consumes results.
    modport master (
        output In_Valid,
        output Input_State,
        output Bypass,
        output Out_Ready,
        input  In_Ready,
        input  Out_Valid,
        input  Output_State
    );

    // Block side: the MixColumns stage itself.
    modport slave (
        input  In_Valid,
        input  Input_State,
        input  Bypass,
        input  Out_Ready,
        output In_Ready,
        output Out_Valid,
        output Output_State
    );
endinterface

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns stage.
// One 32-bit column of the latched state is mixed per clock, so a block
// takes four compute cycles. The final AES round skips MixColumns, which
// is handled by the Bypass flag: the state is passed through unchanged.
// Byte s(r,c) of a state sits at bits [127-32c-8r -: 8].

// GF(2^8) multiply-by-two (xtime), reduced by the AES polynomial 0x11b.
module mult (
    input  logic [7:0] a,
    output logic [7:0] y
);
    assign y = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
endmodule

module mix_columns_seq (
    input  logic                 clk,
    input  logic                 rst,
    mix_columns_seq_if.slave     bus,
    output logic [1:0]           dbg_state
);
    localparam int BYTE = 8;
    localparam int WORD = 32;
    localparam int Nb   = 128;
    localparam int ZERO = 0;

    localparam logic [1:0] COL_FIRST = 2'(ZERO);
    localparam logic [1:0] COL_LAST  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      col_q, col_d;
    logic [Nb-1:0]   src_q, src_d;
    logic [Nb-1:0]   out_q, out_d;
    logic            out_valid_q, out_valid_d;

    logic [WORD-1:0] col_in;
    logic [WORD-1:0] col_out;
    logic [BYTE-1:0] a0, a1, a2, a3;
    logic [BYTE-1:0] m0, m1, m2, m3;
    logic            in_ready;
    logic            accept;
    logic            take_out;

    // In_Ready is combinational from Out_Ready so a finished block can be
    // handed off and the next one accepted on the same edge.
    assign in_ready = !rst && ((state_q == IDLE) ||
                               ((state_q == DONE) && bus.Out_Ready));
    assign accept   = bus.In_Valid && in_ready;
    assign take_out = (state_q == DONE) && bus.Out_Ready;

    assign bus.In_Ready     = in_ready;
    assign bus.Out_Valid    = out_valid_q;
    assign bus.Output_State = out_q;
    assign dbg_state        = state_q;

    // Pick the source column currently being mixed.
    always_comb begin
        col_in = '0;
        case (col_q)
            2'd0:    col_in = src_q[Nb-1        -: WORD];
            2'd1:    col_in = src_q[Nb-1-WORD   -: WORD];
            2'd2:    col_in = src_q[Nb-1-2*WORD -: WORD];
            default: col_in = src_q[Nb-1-3*WORD -: WORD];
        endcase
    end

    // Row 0 of the column is the most significant byte.
    assign {a0, a1, a2, a3} = col_in;

    mult u_mult0 (.a(a0), .y(m0));
    mult u_mult1 (.a(a1), .y(m1));
    mult u_mult2 (.a(a2), .y(m2));
    mult u_mult3 (.a(a3), .y(m3));

    // Circulant matrix {2,3,1,1}; 3a is built as 2a ^ a.
    always_comb begin
        col_out = {
            m0 ^ (m1 ^ a1) ^ a2 ^ a3,
            a0 ^ m1 ^ (m2 ^ a2) ^ a3,
            a0 ^ a1 ^ m2 ^ (m3 ^ a3),
            (m0 ^ a0) ^ a1 ^ a2 ^ m3
        };
    end

    // Next-state logic: accept, column sequencing and result hand-off.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        src_d       = src_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    src_d = bus.Input_State;
                    col_d = COL_FIRST;
                    if (bus.Bypass) begin
                        // Last round: the latched state is the result.
                        out_d       = bus.Input_State;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = CALC;
                    end
                end else if (take_out) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            CALC: begin
                case (col_q)
                    2'd0:    out_d[Nb-1        -: WORD] = col_out;
                    2'd1:    out_d[Nb-1-WORD   -: WORD] = col_out;
                    2'd2:    out_d[Nb-1-2*WORD -: WORD] = col_out;
                    default: out_d[Nb-1-3*WORD -: WORD] = col_out;
                endcase
                col_d = col_q + 2'd1;
                if (col_q == COL_LAST) begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            src_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            src_q       <= src_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_mix_columns_seq.sv
// Testbench for mix_columns_seq: directed vectors with literal expectations
// plus a byte-level MixColumns reference model checked every cycle.
module tb_mix_columns_seq;
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    mix_columns_seq_if bus ();

    mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] COLS_IN  = 128'hdb135345f20a225c01010101d4d4d4d5;
    localparam logic [127:0] COLS_OUT = 128'h8e4da1bc9fdc589d01010101d5d5d7d6;
    localparam logic [127:0] BYP_IN   = 128'h00112233445566778899aabbccddeeff;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   check_en = 0;

    logic [127:0] exp_q[$];
    int           rdy_q[$];

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // General GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        logic       hi;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_model(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a[4];
        logic [7:0]   b;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
            for (int k = 0; k < 4; k++) begin
                b = gmul(8'h02, a[k]) ^ gmul(8'h03, a[(k+1)%4]) ^ a[(k+2)%4] ^ a[(k+3)%4];
                r[127 - 32*c - 8*k -: 8] = b;
            end
        end
        return r;
    endfunction

    // ---------------- scoreboard / compare process ----------------
    // Sampled on the falling edge; predicts handshakes of the next rising edge.
    initial begin
        bit ev;
        bit eir;
        forever begin
            @(negedge clk);
            if (check_en) begin
                ev  = (exp_q.size() > 0) && (cyc >= rdy_q[0]);
                eir = !rst && ((exp_q.size() == 0) || (ev && bus.Out_Ready));
                check("out_valid", 128'(bus.Out_Valid), 128'(ev));
                check("in_ready", 128'(bus.In_Ready), 128'(eir));
                if (ev) check("out_state", bus.Output_State, exp_q[0]);
                if (rst) begin
                    exp_q.delete();
                    rdy_q.delete();
                end else begin
                    if (ev && bus.Out_Ready) begin
                        void'(exp_q.pop_front());
                        void'(rdy_q.pop_front());
                    end
                    if (bus.In_Valid && eir) begin
                        exp_q.push_back(bus.Bypass ? bus.Input_State : mix_model(bus.Input_State));
                        rdy_q.push_back(bus.Bypass ? cyc + 1 : cyc + 5);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [127:0] st, input logic byp, input bit hold, output int waited);
        bit acc;
        waited = 0;
        acc    = 1'b0;
        bus.In_Valid    = 1'b1;
        bus.Input_State = st;
        bus.Bypass      = byp;
        do begin
            @(negedge clk);
            acc = bus.In_Ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!acc && waited < 50);
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end
        if (!hold) bus.In_Valid = 1'b0;
        // Payload is don't-care after the accept edge.
        bus.Input_State = {$urandom, $urandom, $urandom, $urandom};
        bus.Bypass      = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.Out_Valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w;
        int lat;
        int drain;
        logic [127:0] st;

        rst             = 1'b1;
        bus.In_Valid    = 1'b0;
        bus.Input_State = '0;
        bus.Bypass      = 1'b0;
        bus.Out_Ready   = 1'b0;

        // Pin the reference model to known vectors.
        check("model_fips", mix_model(FIPS_IN), FIPS_OUT);
        check("model_cols", mix_model(COLS_IN), COLS_OUT);

        @(posedge clk);
        #1;
        check("rst_in_ready", 128'(bus.In_Ready), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_out_valid", 128'(bus.Out_Valid), 128'd0);
        check("reset_out_state", bus.Output_State, 128'd0);
        check("reset_in_ready_after", 128'(bus.In_Ready), 128'd1);
        check_en = 1'b1;

        // FIPS-197 round-1 column mix, then backpressure.
        send(FIPS_IN, 1'b0, 1'b0, w);
        wait_valid(lat);
        check("fips_latency", 128'(lat), 128'd4);
        check("fips_result", bus.Output_State, FIPS_OUT);
        repeat (10) begin
            @(posedge clk);
            #1;
            check("bp_valid", 128'(bus.Out_Valid), 128'd1);
            check("bp_state", bus.Output_State, FIPS_OUT);
            check("bp_in_ready", 128'(bus.In_Ready), 128'd0);
        end

        // Release backpressure together with a new block: same-edge hand-off.
        bus.Out_Ready = 1'b1;
        send(COLS_IN, 1'b0, 1'b0, w);
        check("handoff_accept_wait", 128'(w), 128'd1);
        wait_valid(lat);
        check("cols_latency", 128'(lat), 128'd4);
        check("cols_result", bus.Output_State, COLS_OUT);

        // Final-round bypass.
        send(BYP_IN, 1'b1, 1'b0, w);
        wait_valid(lat);
        check("bypass_latency", 128'(lat), 128'd0);
        check("bypass_result", bus.Output_State, BYP_IN);

        // Reset in the middle of a computation.
        send(FIPS_IN, 1'b0, 1'b0, w);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 128'(bus.Out_Valid), 128'd0);
        check("midrst_out_state", bus.Output_State, 128'd0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 128'(bus.In_Ready), 128'd1);
        send(COLS_IN, 1'b0, 1'b0, w);
        wait_valid(lat);
        check("post_rst_latency", 128'(lat), 128'd4);
        check("post_rst_result", bus.Output_State, COLS_OUT);

        // Streaming: In_Valid and Out_Ready held high.
        for (int i = 0; i < 8; i++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            send(st, 1'b0, 1'b1, w);
            if (i > 0) check("stream_spacing", 128'(w), 128'd5);
        end
        bus.In_Valid = 1'b0;

        drain = 0;
        while (exp_q.size() > 0 && drain < 40) begin
            @(posedge clk);
            #1;
            drain++;
        end
        check("drained", 128'(exp_q.size()), 128'd0);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mix_columns_seq.md
# mix_columns_seq

Sequential AES MixColumns stage: accepts a 128-bit state after ShiftRows, transforms one 32-bit column per clock using four instances of the team's `mult` xtime byte multiplier, and presents the 128-bit result to AddRoundKey. It uses a valid/ready handshake on both sides and has a bypass for the final round, where MixColumns is skipped. It sits in the round datapath between ShiftRows and AddRoundKey.

## Interface
- BYTE, 8, byte width
- WORD, 32, column width
- ZERO, 0, low index
- Nb, 128, state width
- Nr, 10, round count (informational; not used in logic)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- In_Valid  in  1  Input_State and Bypass are valid
- In_Ready  out  1  block can accept; a transfer occurs on an edge with In_Valid && In_Ready
- Input_State  in  Nb  state; byte s(r,c) at bits [Nb-1-32c-8r -: 8], so [127:120] = s(0,0)
- Bypass  in  1  sampled on accept; 1 = pass the state through unchanged (last round)
- Out_Valid  out  1  Output_State holds a complete result
- Out_Ready  in  1  consumer takes the result on an edge with Out_Valid && Out_Ready
- Output_State  out  Nb  result, same byte ordering as Input_State

## Operation
- FSM states: IDLE, CALC, DONE. Column counter col is 2 bits.
- IDLE: In_Ready=1. On accept: latch Input_State into the internal register src; clear col. If Bypass=1, copy src into Output_State and go to DONE. Otherwise go to CALC.
- CALC: each edge computes column col of src and writes it into Output_State column col, then increments col. When col==3 is written, go to DONE. In_Ready=0 in CALC.
- Column equations over GF(2^8), with x2 = mult and x3(a) = mult(a)^a:
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- DONE: Out_Valid=1. Output_State stays stable while Out_Ready=0.
  - Out_Ready=1 and no new input: return to IDLE and clear Out_Valid.
  - In_Ready = (state==IDLE) || (state==DONE && Out_Ready). This combinational path from Out_Ready to In_Ready is intended.
  - Output taken and In_Valid=1 on the same edge: accept the new block on that edge and go to CALC, or to DONE if Bypass=1.
- Input_State and Bypass are ignored outside an accept edge, so the source may change immediately after a transfer.
- Partially written Output_State columns during CALC are not valid data. No consumer may use them.

## Timing
- Reset: state=IDLE, col=0, src=0, Output_State=0, Out_Valid=0. In_Ready is forced to 0 while rst=1 and is 1 on the first cycle after rst falls.
- Reset mid-operation (CALC or DONE): the block is aborted and the result discarded. All registers return to their reset values on that edge.
- Normal latency: accept on edge T0; columns 0..3 written on edges T1..T4; Out_Valid=1 after T4. That is 4 cycles from accept to valid.
- Bypass latency: accept on T0; Out_Valid=1 after T0, with Output_State equal to the latched input.
- Throughput with Out_Ready held at 1: one block per 5 cycles. The DONE cycle overlaps the next accept, so the cycles are T0 accept, T1–T4 compute, T5 hand-off plus accept.
- A held Out_Valid never drops without a transfer or a reset.

## Test plan
- FIPS-197 round-1 vector: Input_State=d4bf5d30e0b452aeb84111f11e2798e5, Bypass=0 -> Out_Valid high 4 cycles after accept, Output_State=046681e5e0cb199a48f8d37a2806264c.
- Single-column checks, packed as four columns: db135345 f20a225c 01010101 d4d4d4d5 -> 8e4da1bc 9fdc589d 01010101 d5d5d7d6.
- Bypass=1 with Input_State=00112233445566778899aabbccddeeff -> Out_Valid high the cycle after accept, with identical Output_State.
- Backpressure: hold Out_Ready=0 for 10 cycles after Out_Valid rises -> Output_State and Out_Valid stay stable and In_Ready=0. Then raise Out_Ready together with In_Valid carrying a second vector -> output transfer and new accept happen on the same edge, and the second result is valid 4 cycles later.
- Reset: assert rst on the edge after T2 of a CALC block -> next cycle Out_Valid=0 and Output_State=0; after rst drops, In_Ready=1, and a fresh vector produces the correct result.
- Streaming: 8 random states back-to-back with In_Valid and Out_Ready always 1 -> one result every 5 cycles, each matching the software MixColumns reference model, in order.
